// File: rtl/crack_arbiter.sv
// Downstream controller for two ARC4 crack cores: starts both on interleaved keys,
// claims the first core that reports a printable plaintext and routes its copy-out.
module crack_arbiter #(
  parameter int GUARD_CYCLES = 4,
  parameter int PT_AW        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               rdy,
  output logic [23:0]        key,
  output logic               key_valid,
  output logic [1:0]         core_en,
  output logic [55:0]        core_init_key,
  input  logic [1:0]         core_rdy,
  input  logic [47:0]        core_key,
  input  logic [1:0]         core_key_valid,
  input  logic [1:0]         core_checked,
  output logic [1:0]         core_resume,
  output logic               found,
  output logic [1:0]         core_mem_en,
  input  logic [1:0]         core_wren,
  input  logic [2*PT_AW-1:0] core_addr,
  input  logic [15:0]        core_wrdata,
  output logic [PT_AW-1:0]   pt_addr,
  output logic [7:0]         pt_wrdata,
  output logic               pt_wren,
  output logic [2:0]         dbg_state
);

  // Handshake: en is a start request, taken only on a cycle where rdy is high
  // and both cores report rdy; any other en is dropped, never queued.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SEARCH = 3'd2,
    GRANT  = 3'd3,
    COPY   = 3'd4
  } state_t;

  localparam int GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

  state_t        state, state_nxt;
  logic          win;
  logic          found_q;
  logic [GW-1:0] guard;
  logic [1:0]    gcnt;
  logic [1:0]    hit;
  logic [1:0]    win_mask;
  logic          accept;

  assign hit           = core_checked & core_key_valid;
  assign win_mask      = win ? 2'b10 : 2'b01;
  assign accept        = en & (&core_rdy);
  assign found         = found_q;
  assign core_init_key = {28'h1, 28'h0};
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rdy         = 1'b0;
    core_en     = 2'b00;
    core_resume = 2'b00;
    core_mem_en = 2'b00;
    pt_wren     = 1'b0;
    pt_addr     = '0;
    pt_wrdata   = 8'h00;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        // Lets cores stalled by the previous search finish their found-check.
        core_resume = {2{found_q}} & ~core_key_valid;
        if (accept) state_nxt = START;
      end
      START: begin
        core_en   = 2'b11;
        state_nxt = SEARCH;
      end
      SEARCH: begin
        core_resume = ~{2{|hit}};
        if (|hit)                                state_nxt = GRANT;
        else if ((guard == '0) && (&core_rdy))   state_nxt = IDLE;
      end
      GRANT: begin
        core_resume = win_mask;
        core_mem_en = win_mask;
        if (gcnt == 2'd2) state_nxt = COPY;
      end
      COPY: begin
        core_resume = win_mask;
        core_mem_en = win_mask;
        pt_wren     = core_wren[win];
        pt_addr     = win ? core_addr[2*PT_AW-1:PT_AW] : core_addr[PT_AW-1:0];
        pt_wrdata   = win ? core_wrdata[15:8] : core_wrdata[7:0];
        if (core_rdy[win]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win       <= 1'b0;
      found_q   <= 1'b0;
      key       <= 24'h0;
      key_valid <= 1'b0;
      guard     <= '0;
      gcnt      <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            key_valid <= 1'b0;
            found_q   <= 1'b0;
          end
        end
        START: guard <= GW'(GUARD_CYCLES);
        SEARCH: begin
          gcnt <= 2'd0;
          if (guard != '0) guard <= guard - 1'b1;
          // Lowest hitting index wins, so core 0 takes a tie.
          if (|hit) begin
            win     <= ~hit[0];
            key     <= hit[0] ? core_key[23:0] : core_key[47:24];
            found_q <= 1'b1;
          end
        end
        GRANT: gcnt <= gcnt + 2'd1;
        COPY: begin
          if (core_rdy[win]) key_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/crack_arbiter.md
# crack_arbiter

Downstream controller for two parallel `crack` cores in the ARC4 key search. It starts both cores on interleaved key streams: core 0 searches even keys and core 1 searches odd keys. It detects the first core whose `check` stage reports a printable plaintext, freezes the other core, and hands the shared result plaintext memory to the winner for the copy-out. It reports the winning 24-bit key to the top level together with a valid flag.

## Interface
Parameters:
- `GUARD_CYCLES`, default 4: cycles after the start pulse during which `core_rdy` is ignored.
- `PT_AW`, default 8: address width of the shared plaintext memory.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  start pulse from the top level; accepted only when `rdy` is high.
- `rdy`  out  1  high in IDLE only.
- `key`  out  24  winning key; valid when `key_valid` is high.
- `key_valid`  out  1  key found and plaintext copied.
- `core_en`  out  2  one-cycle start pulse per core.
- `core_init_key`  out  2x28  constant start keys: core 0 = 28'h0, core 1 = 28'h1.
- `core_rdy`  in  2  per-core rdy.
- `core_key`  in  2x24  per-core current key.
- `core_key_valid`  in  2  per-core key_valid.
- `core_checked`  in  2  per-core check-complete flag.
- `core_resume`  out  2  per-core resume.
- `found`  out  1  broadcast to both cores: a key has been claimed.
- `core_mem_en`  out  2  grants the copy-out to the winning core.
- `core_wren`  in  2  per-core final write enable.
- `core_addr`  in  2xPT_AW  per-core final write address.
- `core_wrdata`  in  2x8  per-core final write data.
- `pt_addr`  out  PT_AW  write address to the shared plaintext memory.
- `pt_wrdata`  out  8  write data to the shared plaintext memory.
- `pt_wren`  out  1  write enable to the shared plaintext memory.

## Operation
Per-core hit signal: `hit[i] = core_checked[i] & core_key_valid[i]`, combinational. Registers: `win` (1 bit), `found_q`, `key`, `key_valid`, guard counter, grant counter.

State machine: IDLE, START, SEARCH, GRANT, COPY.
- IDLE: `rdy` = 1.
  - `en & (&core_rdy)` → START. On this edge clear `key_valid` and `found_q`.
  - `en` while either `core_rdy` is low is ignored.
  - `core_resume[i] = found_q & ~core_key_valid[i]`. This lets cores stalled by a previous search run on to their found-check and return to RESET.
- START: `core_en` = 2'b11 for one cycle; load the guard counter with GUARD_CYCLES; → SEARCH.
- SEARCH:
  - `core_resume = ~{2{|hit}}`, so a hitting core and its peer both stall in check-wait.
  - On any hit: `win` = lowest hitting index, `key <= core_key[win]`, `found_q <= 1`; → GRANT.
  - Otherwise, if the guard counter is 0 and `&core_rdy`, both key ranges are exhausted: `key_valid` stays 0; → IDLE.
  - The guard counter decrements each cycle until it reaches 0.
- GRANT, exactly 3 cycles:
  - `core_resume[win]` = 1, other core 0.
  - `core_mem_en[win]` = 1 on all 3 cycles, which covers the winner's check → verify → found-wait path.
  - → COPY.
- COPY:
  - `pt_addr`, `pt_wrdata` and `pt_wren` are driven from the winner's `core_*` write port.
  - Loser resume is 0.
  - When `core_rdy[win]` = 1: `key_valid <= 1`; → IDLE.
- Outside COPY, `pt_wren` = 0 and `pt_addr`/`pt_wrdata` = 0.
- `found` = `found_q`. It stays high through IDLE until the next START.
- A loser that also holds a valid key stays stalled. Further starts are then blocked until `rst_n`.

## Timing
- Reset values: state IDLE, `rdy` = 1, `key` = 0, `key_valid` = 0, `found` = 0, `core_en` = 0, `core_resume` = 0, `core_mem_en` = 0, `pt_wren` = 0, `pt_addr` = 0, `pt_wrdata` = 0.
- `en` accepted at edge N → `core_en` high in cycle N+1 only.
- Hit at edge H: `found`, `key` and `win` are registered at H; GRANT occupies cycles H+1..H+3; COPY starts at H+4.
- `core_resume` drops in the same cycle as the hit (combinational). A hitting core never advances past check-wait without a grant.
- Simultaneous hits: core 0 wins.
- A hit and exhaustion in the same cycle: the hit wins.
- `key_valid` rises one cycle after COPY sees `core_rdy[win]`, and holds until the next accepted `en`.
- Asynchronous reset mid-operation (any state): all outputs go to their reset values immediately; a copy in progress is abandoned.

## Test plan
- Core 1 hits alone (`core_checked` = 2'b10, `core_key_valid` = 2'b10, `core_key[1]` = 24'h00000B):
  - `core_resume` = 2'b00 in the hit cycle.
  - GRANT: `core_resume` = 2'b10 and `core_mem_en` = 2'b10 for 3 cycles.
  - COPY mirrors core 1 writes (addr 0..5) onto `pt_*`.
  - After `core_rdy[1]` = 1: `key` = 24'h00000B, `key_valid` = 1, `rdy` = 1.
- Both cores hit in the same cycle (keys 24'h00000A and 24'h00000B):
  - `win` = 0, `key` = 24'h00000A.
  - `core_resume[1]` stays 0 through COPY.
  - COPY ignores all core 1 writes.
- Exhaustion: `core_rdy` = 2'b11 after the guard expires, no hits → return to IDLE, `key_valid` = 0, `core_mem_en` never asserted.
- Guard: `core_rdy` held at 2'b11 for the 4 cycles after `core_en`, then dropped → state remains SEARCH.
- `en` while `core_rdy` = 2'b01 → ignored: no `core_en` pulse, `rdy` stays 1.
- `rst_n` pulsed low mid-COPY → `pt_wren` = 0, `found` = 0, `key_valid` = 0, `rdy` = 1 asynchronously.
